// File: rtl/msrv32_pkg.sv
// Shared constants for the writeback arbiter slice.
//   REG_ADDR_W : width of an integer register address (x0..x31)
//   NUM_REGS   : number of integer registers (and scoreboard entries)
//   REQ_*      : requester slot numbers on the arbiter's request vectors
package msrv32_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_CSR = 2;

    // x0 is hard-wired to zero; writes to it are consumed but never performed.
    function automatic logic is_x0(input logic [REG_ADDR_W-1:0] addr);
        return (addr == '0);
    endfunction

endpackage

// File: rtl/msrv32_wb_arbiter_if.sv
// Writeback bus between the requesters/issue stage and the arbiter.
//   req_valid_in   : per-requester result valid
//   req_rd_addr_in : per-requester destination register, [5*i +: 5]
//   req_data_in    : per-requester result, [XLEN*i +: XLEN]
//   req_ready_out  : one-hot grant back to the requesters
//   rsv_en_in      : issue stage reserves a destination this cycle
//   rsv_addr_in    : register being reserved
//   wr_en_out      : register-file write enable
//   rd_addr_out    : register-file write address
//   rd_out         : register-file write data
//   busy_out       : per-register pending-write flags
// master = requesters/issue/register-file side, slave = arbiter.
interface msrv32_wb_arbiter_if
    import msrv32_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 32
);
    logic [NUM_REQ-1:0]            req_valid_in;
    logic [REG_ADDR_W*NUM_REQ-1:0] req_rd_addr_in;
    logic [XLEN*NUM_REQ-1:0]       req_data_in;
    logic [NUM_REQ-1:0]            req_ready_out;
    logic                          rsv_en_in;
    logic [REG_ADDR_W-1:0]         rsv_addr_in;
    logic                          wr_en_out;
    logic [REG_ADDR_W-1:0]         rd_addr_out;
    logic [XLEN-1:0]               rd_out;
    logic [NUM_REGS-1:0]           busy_out;

    modport master (
        output req_valid_in, req_rd_addr_in, req_data_in, rsv_en_in, rsv_addr_in,
        input  req_ready_out, wr_en_out, rd_addr_out, rd_out, busy_out
    );

    modport slave (
        input  req_valid_in, req_rd_addr_in, req_data_in, rsv_en_in, rsv_addr_in,
        output req_ready_out, wr_en_out, rd_addr_out, rd_out, busy_out
    );
endinterface

// File: rtl/msrv32_rr_arbiter.sv
// Combinational round-robin arbiter.
//   i_valid : request vector
//   i_ptr   : highest-priority index this cycle
//   o_grant : one-hot grant (all zero when nothing is valid)
//   o_idx   : encoded grant index (0 when nothing is valid)
//   o_any   : some request was granted
module msrv32_rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        // Scan from the pointer upwards with wrap; first valid requester wins.
        for (int k = 0; k < NUM_REQ; k++) begin
            int cand;
            cand = int'(i_ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!o_any && i_valid[cand]) begin
                o_any         = 1'b1;
                o_grant[cand] = 1'b1;
                o_idx         = IDX_W'(cand);
            end
        end
    end
endmodule

// File: rtl/msrv32_wb_arbiter.sv
// Writeback arbiter for the single integer register-file write port.
//   ms_riscv32_mp_clk_in : clock, rising edge
//   ms_riscv32_mp_rst_in : synchronous active-high reset
//   bus                  : writeback interface (slave side), see msrv32_wb_arbiter_if
// Round-robin grant is combinational; the chosen result is registered once and
// presented to the register file the following cycle. A 32-entry scoreboard
// tracks reserved-but-not-yet-written destinations.
module msrv32_wb_arbiter
    import msrv32_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 32
) (
    input  logic                 ms_riscv32_mp_clk_in,
    input  logic                 ms_riscv32_mp_rst_in,
    msrv32_wb_arbiter_if.slave   bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0]      r_ptr;
    logic                  r_wr_en;
    logic [REG_ADDR_W-1:0] r_rd_addr;
    logic [XLEN-1:0]       r_rd_data;
    logic [NUM_REGS-1:0]   r_busy;

    logic [NUM_REQ-1:0]    w_grant;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_any;
    logic                  w_xfer;
    logic [REG_ADDR_W-1:0] w_sel_addr;
    logic [XLEN-1:0]       w_sel_data;

    msrv32_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .i_valid (bus.req_valid_in),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Ready is masked during reset so nothing is consumed and then dropped.
    assign bus.req_ready_out = ms_riscv32_mp_rst_in ? '0 : w_grant;
    assign w_xfer            = w_any && !ms_riscv32_mp_rst_in;

    assign w_sel_addr = bus.req_rd_addr_in[REG_ADDR_W*w_idx +: REG_ADDR_W];
    assign w_sel_data = bus.req_data_in[XLEN*w_idx +: XLEN];

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            if (w_idx == IDX_W'(NUM_REQ - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= w_idx + 1'b1;
            end
        end
    end

    // Output stage: address/data hold when idle, enable pulses per transfer.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            r_wr_en   <= 1'b0;
            r_rd_addr <= '0;
            r_rd_data <= '0;
        end else if (w_xfer) begin
            r_wr_en   <= !is_x0(w_sel_addr);
            r_rd_addr <= w_sel_addr;
            r_rd_data <= w_sel_data;
        end else begin
            r_wr_en   <= 1'b0;
        end
    end

    // Scoreboard: a reservation in the same cycle as a completing write to the
    // same register belongs to a newer producer, so the set takes priority.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            r_busy <= '0;
        end else begin
            r_busy[0] <= 1'b0;
            for (int r = 1; r < NUM_REGS; r++) begin
                if (bus.rsv_en_in && (bus.rsv_addr_in == REG_ADDR_W'(r))) begin
                    r_busy[r] <= 1'b1;
                end else if (r_wr_en && (r_rd_addr == REG_ADDR_W'(r))) begin
                    r_busy[r] <= 1'b0;
                end
            end
        end
    end

    // The register being written this cycle is forwarded by the file, so it
    // already reads as available.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_busy
            assign bus.busy_out[gi] = r_busy[gi] &
                                      ~(r_wr_en && (r_rd_addr == REG_ADDR_W'(gi)));
        end
    endgenerate

    assign bus.wr_en_out   = r_wr_en;
    assign bus.rd_addr_out = r_rd_addr;
    assign bus.rd_out      = r_rd_data;

endmodule

// File: tb/tb_msrv32_wb_arbiter.sv
module tb_msrv32_wb_arbiter;
    import msrv32_pkg::*;

    localparam int NREQ = 3;
    localparam int XL   = 32;

    logic clk;
    logic rst;

    msrv32_wb_arbiter_if #(.NUM_REQ(NREQ), .XLEN(XL)) bus ();

    msrv32_wb_arbiter #(.NUM_REQ(NREQ), .XLEN(XL)) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .bus                  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        chk_ad;
        logic [4:0]  a;
        logic [31:0] d;
    } wexp_t;

    typedef struct {
        logic [2:0]  valid;
        logic [14:0] addrs;
        logic [95:0] datas;
        logic [2:0]  exp_ready;
    } vec_t;

    wexp_t q[$];
    vec_t  vecs[15];
    int    n_vec = 0;
    int    n_mis = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic [14:0] a, input logic [95:0] d);
        bus.req_valid_in   = v;
        bus.req_rd_addr_in = a;
        bus.req_data_in    = d;
    endtask

    task automatic rsv(input logic en, input logic [4:0] a);
        bus.rsv_en_in   = en;
        bus.rsv_addr_in = a;
    endtask

    // One cycle: check last cycle's write and this cycle's grant/busy at the
    // falling edge, queue the write this grant should produce, then advance.
    task automatic tick(input logic [2:0] exp_ready, input logic [31:0] exp_busy);
        wexp_t e;
        wexp_t n;
        @(negedge clk);
        if (q.size() == 0) begin
            chk("queue_empty", 32'd1, 32'd0);
        end else begin
            e = q.pop_front();
            chk("wr_en", {31'd0, bus.wr_en_out}, {31'd0, e.wr});
            if (e.chk_ad) begin
                chk("rd_addr", {27'd0, bus.rd_addr_out}, {27'd0, e.a});
                chk("rd_data", bus.rd_out, e.d);
            end
        end
        chk("ready", {29'd0, bus.req_ready_out}, {29'd0, exp_ready});
        chk("busy", bus.busy_out, exp_busy);
        $display("cycle valid=%b ready=%b wr_en=%b addr=%0d data=%h busy=%h",
                 bus.req_valid_in, bus.req_ready_out, bus.wr_en_out,
                 bus.rd_addr_out, bus.rd_out, bus.busy_out);
        n.wr = 1'b0; n.chk_ad = 1'b0; n.a = '0; n.d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (exp_ready[i]) begin
                n.a      = bus.req_rd_addr_in[5*i +: 5];
                n.d      = bus.req_data_in[32*i +: 32];
                n.chk_ad = 1'b1;
                n.wr     = (n.a != 5'd0);
            end
        end
        q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] B9 = 32'h0000_0200;
    localparam logic [31:0] B3 = 32'h0000_0008;

    initial begin
        wexp_t rq;
        // Round-robin vectors; pointer starts at 0 after reset.
        vecs[0]  = '{3'b111, {5'd3, 5'd2, 5'd1},  {32'hA2, 32'hA1, 32'hA0}, 3'b001};
        vecs[1]  = '{3'b010, {5'd0, 5'd5, 5'd0},  {32'h0, 32'hDEADBEEF, 32'h0}, 3'b010};
        vecs[2]  = '{3'b100, {5'd7, 5'd0, 5'd0},  {32'h77, 32'h0, 32'h0}, 3'b100};
        vecs[3]  = '{3'b111, {5'd13, 5'd12, 5'd11}, {32'hC3, 32'hC2, 32'hC1}, 3'b001};
        vecs[4]  = '{3'b111, {5'd13, 5'd12, 5'd11}, {32'hC3, 32'hC2, 32'hC1}, 3'b010};
        vecs[5]  = '{3'b111, {5'd13, 5'd12, 5'd11}, {32'hC3, 32'hC2, 32'hC1}, 3'b100};
        vecs[6]  = '{3'b111, {5'd23, 5'd22, 5'd21}, {32'hD3, 32'hD2, 32'hD1}, 3'b001};
        vecs[7]  = '{3'b111, {5'd23, 5'd22, 5'd21}, {32'hD3, 32'hD2, 32'hD1}, 3'b010};
        vecs[8]  = '{3'b111, {5'd23, 5'd22, 5'd21}, {32'hD3, 32'hD2, 32'hD1}, 3'b100};
        vecs[9]  = '{3'b000, {5'd1, 5'd1, 5'd1},  {32'h1, 32'h1, 32'h1}, 3'b000};
        vecs[10] = '{3'b001, {5'd4, 5'd4, 5'd0},  {32'h9, 32'h8, 32'h7}, 3'b001};
        vecs[11] = '{3'b101, {5'd12, 5'd6, 5'd12}, {32'hE2, 32'hE1, 32'hE0}, 3'b100};
        vecs[12] = '{3'b110, {5'd12, 5'd12, 5'd6}, {32'hF2, 32'hF1, 32'hF0}, 3'b010};
        vecs[13] = '{3'b011, {5'd2, 5'd31, 5'd30}, {32'h12, 32'h11, 32'h10}, 3'b001};
        vecs[14] = '{3'b000, {5'd0, 5'd0, 5'd0},  {32'h0, 32'h0, 32'h0}, 3'b000};

        // Reset with every requester valid: nothing granted, outputs cleared.
        rst = 1'b1;
        drive(3'b111, {5'd3, 5'd2, 5'd1}, {32'hA2, 32'hA1, 32'hA0});
        rsv(1'b0, 5'd0);
        @(posedge clk); #1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst_ready", {29'd0, bus.req_ready_out}, 32'd0);
            chk("rst_wr_en", {31'd0, bus.wr_en_out}, 32'd0);
            chk("rst_busy", bus.busy_out, 32'd0);
            $display("reset cycle %0d ready=%b wr_en=%b busy=%h",
                     c, bus.req_ready_out, bus.wr_en_out, bus.busy_out);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        q.delete();
        rq.wr = 1'b0; rq.chk_ad = 1'b1; rq.a = '0; rq.d = '0;
        q.push_back(rq);

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].valid, vecs[i].addrs, vecs[i].datas);
            tick(vecs[i].exp_ready, 32'd0);
        end
        // Pointer is now at REQ_LSU.

        // Reserve x9, then write it via the LSU slot.
        drive(3'b000, '0, '0);
        rsv(1'b1, 5'd9);
        tick(3'b000, 32'd0);
        rsv(1'b0, 5'd0);
        drive(3'b010, {5'd0, 5'd9, 5'd0}, {32'h0, 32'h55, 32'h0});
        tick(3'b010, B9);
        drive(3'b000, '0, '0);
        tick(3'b000, 32'd0);   // write of x9 visible: forwarded as not busy
        tick(3'b000, 32'd0);   // scoreboard entry cleared

        // Race: reservation coincides with the completing write.
        drive(3'b100, {5'd9, 5'd0, 5'd0}, {32'h66, 32'h0, 32'h0});
        tick(3'b100, 32'd0);
        drive(3'b000, '0, '0);
        rsv(1'b1, 5'd9);
        tick(3'b000, 32'd0);
        rsv(1'b0, 5'd0);
        tick(3'b000, B9);

        // Reserving x0 never marks it busy.
        rsv(1'b1, 5'd0);
        tick(3'b000, B9);
        rsv(1'b0, 5'd0);
        tick(3'b000, B9);

        // Mid-operation reset right after a grant.
        rsv(1'b1, 5'd3);
        drive(3'b001, {5'd0, 5'd0, 5'd4}, {32'h0, 32'h0, 32'h99});
        tick(3'b001, B9);
        rsv(1'b0, 5'd0);
        rst = 1'b1;
        drive(3'b111, {5'd3, 5'd2, 5'd1}, {32'hB2, 32'hB1, 32'hB0});
        tick(3'b000, B9 | B3);
        rst = 1'b0;
        drive(3'b000, '0, '0);
        tick(3'b000, 32'd0);   // pending write dropped, scoreboard cleared
        drive(3'b111, {5'd3, 5'd2, 5'd1}, {32'hB2, 32'hB1, 32'hB0});
        tick(3'b001, 32'd0);   // pointer back at REQ_ALU
        drive(3'b000, '0, '0);
        tick(3'b000, 32'd0);
        chk("queue_left", q.size(), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
